// File: rtl/image_rx_framer_if.sv
// Signal bundle around the image receive framer: UART byte input, result-sender
// handshake, pixel stream with coordinates, and RTS/overflow/abort status.
interface image_rx_framer_if #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [7:0]    uart_data;
  logic          uart_data_rdy;
  logic          results_sent;
  logic [7:0]    pixel;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_last;
  logic          fpga_can_receive;
  logic          overflow;
  logic          frame_abort;

  // Framer side
  modport slave (
    input  uart_data, uart_data_rdy, results_sent, pixel_ready,
    output pixel, pixel_valid, pix_x, pix_y, frame_last,
           fpga_can_receive, overflow, frame_abort
  );

  // Environment side (UART receiver, pipeline, result sender)
  modport master (
    output uart_data, uart_data_rdy, results_sent, pixel_ready,
    input  pixel, pixel_valid, pix_x, pix_y, frame_last,
           fpga_can_receive, overflow, frame_abort
  );
endinterface

// File: rtl/image_rx_framer.sv
// Buffers UART image bytes in a first-word-fall-through FIFO and streams one IMG_W x IMG_H
// frame with pixel coordinates, driving RTS. Optional inter-byte abort: FRAME_TIMEOUT_EN.
module image_rx_framer #(
  parameter int IMG_W          = 160,
  parameter int IMG_H          = 120,
  parameter int FIFO_DEPTH     = 16,
  parameter int RTS_MARGIN     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  image_rx_framer_if.slave io_bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int RW   = $clog2(NPIX + 1);
  localparam int OW   = $clog2(NPIX);

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [CW-1:0] C_FULL   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_HI     = CW'(FIFO_DEPTH - RTS_MARGIN);
  localparam logic [CW-1:0] C_LO     = CW'(FIFO_DEPTH / 2);
  localparam logic [RW-1:0] RX_N     = RW'(NPIX);
  localparam logic [RW-1:0] RX_LAST  = RW'(NPIX - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH, S_HOLD} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [RW-1:0] r_rx_count;
  logic [OW-1:0] r_out_count;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic          r_rts;
  logic          r_overflow;

  logic w_stream_state;
  logic w_accept_state;
  logic w_pix_valid;
  logic w_pop;
  logic w_push;
  logic w_last;
  logic w_rx_done;

  assign w_stream_state = (r_state == S_RECV) || (r_state == S_FLUSH);
  assign w_accept_state = (r_state == S_IDLE) || (r_state == S_RECV);
  assign w_pix_valid    = w_stream_state && (r_count != '0);
  assign w_pop          = w_pix_valid && io_bus.pixel_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle
  assign w_push         = io_bus.uart_data_rdy && w_accept_state && (r_rx_count < RX_N)
                          && ((r_count < C_FULL) || w_pop);
  assign w_last         = w_pix_valid && (r_out_count == OUT_LAST);
  assign w_rx_done      = w_push && (r_rx_count == RX_LAST);

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_abort;
  logic          w_to_run;
  logic          w_to_fire;

  // Only an idle line with nothing buffered and RTS asserted counts as a stall
  assign w_to_run  = (r_state == S_RECV) && (r_count == '0) && r_rts && !w_push;
  assign w_to_fire = w_to_run && (r_to_cnt == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_abort <= w_to_fire;
      if (w_to_run && !w_to_fire) r_to_cnt <= r_to_cnt + 1'b1;
      else                        r_to_cnt <= '0;
    end
  end

  assign io_bus.frame_abort = r_abort;
`else
  assign io_bus.frame_abort = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= io_bus.uart_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_count  <= '0;
      r_out_count <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_rts       <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      if (io_bus.uart_data_rdy && !w_push) r_overflow <= 1'b1;

      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_rx_count <= r_rx_count + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_out_count <= r_out_count + 1'b1;
        if (r_pix_x == X_LAST) begin
          r_pix_x <= '0;
          r_pix_y <= r_pix_y + 1'b1;
        end else begin
          r_pix_x <= r_pix_x + 1'b1;
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Later assignments below override the generic counter updates above
      case (r_state)
        S_IDLE: begin
          r_rts <= 1'b1;
          if (w_rx_done) begin
            r_state <= S_FLUSH;
            r_rts   <= 1'b0;
          end else if (w_push) begin
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (r_rts && (r_count >= C_HI))       r_rts <= 1'b0;
          else if (!r_rts && (r_count <= C_LO)) r_rts <= 1'b1;
          if (w_rx_done) begin
            r_state <= S_FLUSH;
            r_rts   <= 1'b0;
          end
`ifdef FRAME_TIMEOUT_EN
          if (w_to_fire) begin
            r_state     <= S_IDLE;
            r_rts       <= 1'b1;
            r_rx_count  <= '0;
            r_out_count <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
          end
`endif
        end
        S_FLUSH: begin
          r_rts <= 1'b0;
          if (w_pop && w_last) begin
            r_state     <= S_HOLD;
            r_rx_count  <= '0;
            r_out_count <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
          end
        end
        S_HOLD: begin
          r_rts <= 1'b0;
          if (io_bus.results_sent) begin
            r_state <= S_IDLE;
            r_rts   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rts   <= 1'b1;
        end
      endcase
    end
  end

  // Pixel is forced to zero whenever nothing is presented, so the unreset buffer never leaks out
  assign io_bus.pixel            = w_pix_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign io_bus.pixel_valid      = w_pix_valid;
  assign io_bus.pix_x            = r_pix_x;
  assign io_bus.pix_y            = r_pix_y;
  assign io_bus.frame_last       = w_last;
  assign io_bus.fpga_can_receive = r_rts;
  assign io_bus.overflow         = r_overflow;
endmodule

// File: tb/tb_image_rx_framer.sv
// Bench for image_rx_framer: directed scenarios plus a random phase, all checked each
// cycle against a queue-based reference model of the framing and RTS rules.
`timescale 1ns/1ps
module tb_image_rx_framer;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;
  localparam int TO     = 50;
  localparam int PH_IDLE = 0, PH_RECV = 1, PH_FLUSH = 2, PH_HOLD = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  image_rx_framer_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  image_rx_framer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH),
    .RTS_MARGIN(MARGIN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] m_q[$];
  int         m_ph, m_rx, m_out;
  bit         m_rts, m_ovf, m_abort;
`ifdef FRAME_TIMEOUT_EN
  int         m_tcnt;
`endif

  logic [7:0] lg_px[$];
  int         lg_x[$], lg_y[$];
  bit         lg_last[$];
  int         abort_seen;
  logic [7:0] exp_frame[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ph = PH_IDLE; m_rx = 0; m_out = 0;
    m_rts = 1'b1; m_ovf = 1'b0; m_abort = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    m_tcnt = 0;
`endif
  endtask

  // One clock edge of the reference behaviour, from the inputs held during that cycle
  task automatic model_clock(input bit urdy, input logic [7:0] d, input bit prdy, input bit rs);
    int sz;
    bit vld, pop, last, acc, nrts;
    sz   = m_q.size();
    vld  = (m_ph == PH_RECV || m_ph == PH_FLUSH) && sz > 0;
    pop  = vld && prdy;
    last = vld && (m_out == NPIX - 1);
    acc  = urdy && (m_ph == PH_IDLE || m_ph == PH_RECV) && (m_rx < NPIX) && (sz < DEPTH || pop);
    m_abort = 1'b0;
    if (urdy && !acc) m_ovf = 1'b1;
    if (pop) begin void'(m_q.pop_front()); m_out++; end
    if (acc) begin m_q.push_back(d); m_rx++; end
`ifdef FRAME_TIMEOUT_EN
    if (m_ph != PH_RECV) m_tcnt = 0;
`endif
    case (m_ph)
      PH_IDLE: if (acc) begin
        if (m_rx == NPIX) begin m_ph = PH_FLUSH; m_rts = 1'b0; end
        else m_ph = PH_RECV;
      end
      PH_RECV: begin
        nrts = m_rts;
        if (m_rts && sz >= DEPTH - MARGIN) nrts = 1'b0;
        else if (!m_rts && sz <= DEPTH / 2) nrts = 1'b1;
`ifdef FRAME_TIMEOUT_EN
        if (sz == 0 && m_rts && !acc) m_tcnt++;
        else m_tcnt = 0;
`endif
        m_rts = nrts;
        if (m_rx == NPIX) begin m_ph = PH_FLUSH; m_rts = 1'b0; end
`ifdef FRAME_TIMEOUT_EN
        if (m_tcnt == TO) begin
          m_tcnt = 0; m_abort = 1'b1; m_ph = PH_IDLE; m_rts = 1'b1; m_rx = 0; m_out = 0;
        end
`endif
      end
      PH_FLUSH: if (pop && last) begin m_ph = PH_HOLD; m_rx = 0; m_out = 0; end
      default:  if (rs) begin m_ph = PH_IDLE; m_rts = 1'b1; end
    endcase
  endtask

  task automatic step(input bit urdy, input logic [7:0] d, input bit prdy, input bit rs, input bit rst);
    bit vld;
    reset = rst;
    bus.uart_data_rdy = urdy;
    bus.uart_data     = d;
    bus.pixel_ready   = prdy;
    bus.results_sent  = rs;
    @(negedge clock);
    vld = (m_ph == PH_RECV || m_ph == PH_FLUSH) && m_q.size() > 0;
    chk("pixel_valid", 32'(bus.pixel_valid), 32'(vld));
    chk("pixel", 32'(bus.pixel), vld ? 32'(m_q[0]) : 32'd0);
    chk("pix_x", 32'(bus.pix_x), 32'(m_out % IMG_W));
    chk("pix_y", 32'(bus.pix_y), 32'(m_out / IMG_W));
    chk("frame_last", 32'(bus.frame_last), 32'(vld && m_out == NPIX - 1));
    chk("rts", 32'(bus.fpga_can_receive), 32'(m_rts));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("frame_abort", 32'(bus.frame_abort), 32'(m_abort));
    if (bus.pixel_valid === 1'b1 && prdy) begin
      lg_px.push_back(bus.pixel);
      lg_x.push_back(int'(bus.pix_x));
      lg_y.push_back(int'(bus.pix_y));
      lg_last.push_back(bus.frame_last === 1'b1);
    end
    if (bus.frame_abort === 1'b1) abort_seen++;
    @(posedge clock);
    if (rst) model_reset();
    else     model_clock(urdy, d, prdy, rs);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit prdy);
    step(1'b1, d, prdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit prdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, prdy, 1'b0, 1'b0);
  endtask

  task automatic log_clear();
    lg_px.delete(); lg_x.delete(); lg_y.delete(); lg_last.delete();
  endtask

  // Popped pixels must be the frame bytes in order, raster coordinates, last only on the final one
  task automatic check_frame(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, 32'(lg_px.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < lg_px.size(); i++) begin
      chk({tag, "_px"}, 32'(lg_px[i]), 32'(exp[i]));
      chk({tag, "_x"}, 32'(lg_x[i]), 32'(i % IMG_W));
      chk({tag, "_y"}, 32'(lg_y[i]), 32'(i / IMG_W));
      chk({tag, "_last"}, 32'(lg_last[i]), 32'(i == NPIX - 1));
    end
  endtask

  initial begin
    bus.uart_data_rdy = 1'b0;
    bus.uart_data     = 8'h00;
    bus.pixel_ready   = 1'b0;
    bus.results_sent  = 1'b0;
    abort_seen        = 0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();

    // Reset state
    chk("rst_rts", 32'(bus.fpga_can_receive), 32'd1);
    chk("rst_pv", 32'(bus.pixel_valid), 32'd0);
    chk("rst_pixel", 32'(bus.pixel), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    idle(2, 1'b1);

    // Straight-through frame 0x10..0x17
    log_clear(); exp_frame.delete();
    for (int i = 0; i < NPIX; i++) begin
      send(8'(8'h10 + i), 1'b1);
      exp_frame.push_back(8'(8'h10 + i));
    end
    idle(3, 1'b1);
    check_frame("B", exp_frame);
    chk("B_hold_rts", 32'(bus.fpga_can_receive), 32'd0);
    chk("B_hold_pv", 32'(bus.pixel_valid), 32'd0);
    chk("B_ovf", 32'(bus.overflow), 32'd0);

    // Byte during HOLD is dropped; results_sent reopens; next frame starts at 0,0
    send(8'hAA, 1'b1);
    chk("C_ovf", 32'(bus.overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("C_rts", 32'(bus.fpga_can_receive), 32'd1);
    log_clear(); exp_frame.delete();
    send(8'h55, 1'b1);
    exp_frame.push_back(8'h55);
    for (int i = 1; i < NPIX; i++) begin
      exp_frame.push_back(8'($urandom));
      send(exp_frame[i], 1'b1);
    end
    idle(3, 1'b1);
    check_frame("C", exp_frame);

    // RTS watermark and hysteresis
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(8'(8'h20 + i), 1'b0);
    chk("D_rts_hi", 32'(bus.fpga_can_receive), 32'd1);
    idle(1, 1'b0);
    chk("D_rts_lo", 32'(bus.fpga_can_receive), 32'd0);
    idle(2, 1'b1);
    chk("D_rts_still_lo", 32'(bus.fpga_can_receive), 32'd0);
    idle(1, 1'b1);
    chk("D_rts_back", 32'(bus.fpga_can_receive), 32'd1);

    // FIFO filled with no reader, extra byte dropped, contents intact
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    log_clear(); exp_frame.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_frame.push_back(8'($urandom));
      send(exp_frame[i], 1'b0);
    end
    chk("E_ovf_before", 32'(bus.overflow), 32'd0);
    send(8'h99, 1'b0);
    chk("E_ovf", 32'(bus.overflow), 32'd1);
    idle(2, 1'b0);
    chk("E_ovf_sticky", 32'(bus.overflow), 32'd1);
    idle(12, 1'b1);
    check_frame("E", exp_frame);

    // Reset mid-frame discards buffered bytes
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(8'(8'h30 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("F_rts", 32'(bus.fpga_can_receive), 32'd1);
    chk("F_pv", 32'(bus.pixel_valid), 32'd0);
    chk("F_ovf", 32'(bus.overflow), 32'd0);
    log_clear(); exp_frame.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_frame.push_back(8'($urandom));
      send(exp_frame[i], 1'b1);
    end
    idle(3, 1'b1);
    check_frame("F", exp_frame);

`ifdef FRAME_TIMEOUT_EN
    // Stalled frame aborts once, then a full frame follows
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 1'b1);
    abort_seen = 0;
    idle(60, 1'b1);
    chk("H_abort_pulses", 32'(abort_seen), 32'd1);
    chk("H_rts", 32'(bus.fpga_can_receive), 32'd1);
    log_clear(); exp_frame.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_frame.push_back(8'($urandom));
      send(exp_frame[i], 1'b1);
    end
    idle(3, 1'b1);
    check_frame("H", exp_frame);
`endif

    // Random traffic against the model
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 3) != 0, 8'($urandom), ($urandom % 4) != 0, ($urandom % 20) == 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
